// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the EX/ID datapath and the pipeline hazard controller.
// The master side is the core datapath; the slave side is pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              jump_en_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              ex_mem_read_i;
  logic [4:0]        ex_rd_addr_i;
  logic [4:0]        id_rs1_addr_i;
  logic [4:0]        id_rs2_addr_i;
  logic              id_rs1_used_i;
  logic              id_rs2_used_i;
  logic              mdu_start_i;
  logic              mdu_done_i;
  logic              bus_stall_i;

  logic              stall_pc_o;
  logic              stall_if_id_o;
  logic              stall_id_ex_o;
  logic              flush_if_id_o;
  logic              flush_id_ex_o;
  logic              jump_en_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic              mdu_timeout_o;
  logic [1:0]        state_o;

  modport master (
    output jump_en_i, jump_addr_i, ex_mem_read_i, ex_rd_addr_i,
           id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           mdu_start_i, mdu_done_i, bus_stall_i,
    input  stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o,
           flush_id_ex_o, jump_en_o, jump_addr_o, mdu_timeout_o, state_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, ex_mem_read_i, ex_rd_addr_i,
           id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           mdu_start_i, mdu_done_i, bus_stall_i,
    output stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o,
           flush_id_ex_o, jump_en_o, jump_addr_o, mdu_timeout_o, state_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: stalls and flushes PC,
// IF/ID and ID/EX for redirects, load-use, multi-cycle MDU ops and bus stalls.
module pipe_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave ctrl
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MDU_WAIT  = 2'd1,
    JUMP_PEND = 2'd2,
    ILLEGAL   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic              tmo_q, tmo_d;

  logic              stall_pc, stall_if_id, stall_id_ex;
  logic              flush_if_id, flush_id_ex, jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              load_use;

  assign load_use = ctrl.ex_mem_read_i && (ctrl.ex_rd_addr_i != 5'd0) &&
                    ((ctrl.id_rs1_used_i && (ctrl.id_rs1_addr_i == ctrl.ex_rd_addr_i)) ||
                     (ctrl.id_rs2_used_i && (ctrl.id_rs2_addr_i == ctrl.ex_rd_addr_i)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pend_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    tmo_d       = tmo_q;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    stall_id_ex = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = '0;

    unique case (state_q)
      RUN, ILLEGAL: begin
        if (ctrl.bus_stall_i) begin
          {stall_pc, stall_if_id, stall_id_ex} = '1;
          if (ctrl.jump_en_i) begin
            pend_d  = ctrl.jump_addr_i;
            state_d = JUMP_PEND;
          end
        end else if (ctrl.jump_en_i) begin
          jump_en     = 1'b1;
          jump_addr   = ctrl.jump_addr_i;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (ctrl.mdu_start_i) begin
          {stall_pc, stall_if_id, stall_id_ex} = '1;
          cnt_d   = '0;
          state_d = MDU_WAIT;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
      end

      MDU_WAIT: begin
        if (ctrl.mdu_done_i && !ctrl.bus_stall_i) begin
          state_d = RUN;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = RUN;
        end else begin
          {stall_pc, stall_if_id, stall_id_ex} = '1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      JUMP_PEND: begin
        if (ctrl.bus_stall_i) begin
          {stall_pc, stall_if_id, stall_id_ex} = '1;
        end else begin
          jump_en     = 1'b1;
          jump_addr   = pend_q;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          state_d     = RUN;
        end
      end
    endcase

    // The unused encoding behaves like RUN for one cycle but always lands in RUN.
    if (state_q == ILLEGAL) state_d = RUN;
  end

  // Outputs are combinational, so they must also be masked while reset is held.
  assign ctrl.stall_pc_o    = rst && stall_pc;
  assign ctrl.stall_if_id_o = rst && stall_if_id;
  assign ctrl.stall_id_ex_o = rst && stall_id_ex;
  assign ctrl.flush_if_id_o = rst && flush_if_id;
  assign ctrl.flush_id_ex_o = rst && flush_id_ex;
  assign ctrl.jump_en_o     = rst && jump_en;
  assign ctrl.jump_addr_o   = rst ? jump_addr : '0;
  assign ctrl.mdu_timeout_o = tmo_q;
  assign ctrl.state_o       = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level model of the hazard rules.
module tb_pipe_ctrl;
  localparam int ADDR_W = 32;
  localparam int TMO    = 64;

  // {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, jump_en, timeout, state[1:0]}
  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_STL3 = 6'b111000;
  localparam logic [5:0] C_LU   = 6'b110010;
  localparam logic [5:0] C_JMP  = 6'b000111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.ADDR_W(ADDR_W)) bif ();

  pipe_ctrl #(.ADDR_W(ADDR_W), .MDU_TIMEOUT(TMO), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .ctrl(bif)
  );

  // Reference model: a pending redirect is a queued address, an MDU op is a wait count.
  bit          m_in_mdu;
  int unsigned m_waited;
  logic [31:0] m_pend[$];
  bit          m_tmo;

  task automatic model_reset();
    m_in_mdu = 0;
    m_waited = 0;
    m_pend.delete();
    m_tmo    = 0;
  endtask

  function automatic bit hazard();
    if (!bif.ex_mem_read_i || bif.ex_rd_addr_i == 0) return 0;
    return (bif.id_rs1_used_i && bif.id_rs1_addr_i == bif.ex_rd_addr_i) ||
           (bif.id_rs2_used_i && bif.id_rs2_addr_i == bif.ex_rd_addr_i);
  endfunction

  task automatic model_eval(output logic [8:0] c, output logic [31:0] a);
    logic [5:0] k;
    logic [1:0] st;
    k = C_IDLE; st = 2'd0; a = '0;
    if (!rst) begin
      c = '0;
      return;
    end
    if (m_pend.size() != 0) begin
      st = 2'd2;
      if (bif.bus_stall_i) k = C_STL3;
      else begin k = C_JMP; a = m_pend[0]; end
    end else if (m_in_mdu) begin
      st = 2'd1;
      if (!(bif.mdu_done_i && !bif.bus_stall_i) && m_waited != TMO - 1) k = C_STL3;
    end else if (bif.bus_stall_i) k = C_STL3;
    else if (bif.jump_en_i) begin k = C_JMP; a = bif.jump_addr_i; end
    else if (bif.mdu_start_i) k = C_STL3;
    else if (hazard()) k = C_LU;
    c = {k, m_tmo, st};
  endtask

  task automatic model_step();
    if (m_pend.size() != 0) begin
      if (!bif.bus_stall_i) void'(m_pend.pop_front());
    end else if (m_in_mdu) begin
      if (bif.mdu_done_i && !bif.bus_stall_i) m_in_mdu = 0;
      else if (m_waited == TMO - 1) begin m_tmo = 1; m_in_mdu = 0; end
      else m_waited++;
    end else if (bif.bus_stall_i) begin
      if (bif.jump_en_i) m_pend.push_back(bif.jump_addr_i);
    end else if (!bif.jump_en_i && bif.mdu_start_i) begin
      m_in_mdu = 1;
      m_waited = 0;
    end
  endtask

  function automatic logic [8:0] snap();
    return {bif.stall_pc_o, bif.stall_if_id_o, bif.stall_id_ex_o, bif.flush_if_id_o,
            bif.flush_id_ex_o, bif.jump_en_o, bif.mdu_timeout_o, bif.state_o};
  endfunction

  task automatic idle();
    bif.jump_en_i = 0; bif.jump_addr_i = '0; bif.ex_mem_read_i = 0; bif.ex_rd_addr_i = '0;
    bif.id_rs1_addr_i = '0; bif.id_rs2_addr_i = '0; bif.id_rs1_used_i = 0;
    bif.id_rs2_used_i = 0; bif.mdu_start_i = 0; bif.mdu_done_i = 0; bif.bus_stall_i = 0;
  endtask

  task automatic rand_inputs();
    bif.jump_en_i     = ($urandom_range(0, 99) < 15);
    bif.jump_addr_i   = $urandom & 32'hFFFF_FFFC;
    bif.ex_mem_read_i = $urandom_range(0, 1);
    bif.ex_rd_addr_i  = 5'($urandom_range(0, 3));
    bif.id_rs1_addr_i = 5'($urandom_range(0, 3));
    bif.id_rs2_addr_i = 5'($urandom_range(0, 3));
    bif.id_rs1_used_i = $urandom_range(0, 1);
    bif.id_rs2_used_i = $urandom_range(0, 1);
    bif.mdu_start_i   = ($urandom_range(0, 99) < 10);
    bif.mdu_done_i    = ($urandom_range(0, 99) < 20);
    bif.bus_stall_i   = ($urandom_range(0, 99) < 25);
  endtask

  // Advance one clock; inputs are changed only after the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [8:0] got;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      #1 got = snap();
      checks++;
      if (got !== 9'd0 || bif.jump_addr_o !== '0) begin
        errors++;
        $display("FAIL reset_hold got=%b/%h exp=0/0", got, bif.jump_addr_o);
      end
      tick();
    end
    idle();
    rst = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #1 got = snap();
      checks++;
      if (got !== 9'd0) begin errors++; $display("FAIL reset_release got=%b exp=0", got); end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [8:0] got;
    bif.ex_mem_read_i = 1; bif.ex_rd_addr_i = 5; bif.id_rs2_addr_i = 5; bif.id_rs2_used_i = 1;
    bif.id_rs1_addr_i = 3; bif.id_rs1_used_i = 1;
    #1 got = snap();
    checks++;
    if (got !== {C_LU, 1'b0, 2'd0}) begin errors++; $display("FAIL lu_rs2 got=%b exp=%b", got, {C_LU, 3'b000}); end
    tick();
    bif.ex_rd_addr_i = 0; bif.id_rs2_addr_i = 0;
    #1 got = snap();
    checks++;
    if (got !== 9'd0) begin errors++; $display("FAIL lu_x0 got=%b exp=0", got); end
    tick();
    bif.ex_rd_addr_i = 7; bif.id_rs1_addr_i = 7; bif.id_rs2_addr_i = 2;
    #1 got = snap();
    checks++;
    if (got !== {C_LU, 3'b000}) begin errors++; $display("FAIL lu_rs1 got=%b exp=%b", got, {C_LU, 3'b000}); end
    tick();
    bif.id_rs1_used_i = 0;
    #1 got = snap();
    checks++;
    if (got !== 9'd0) begin errors++; $display("FAIL lu_unused got=%b exp=0", got); end
    tick();
    idle();
  endtask

  task automatic test_jump_priority();
    logic [8:0] got;
    bif.ex_mem_read_i = 1; bif.ex_rd_addr_i = 5; bif.id_rs2_addr_i = 5; bif.id_rs2_used_i = 1;
    bif.mdu_start_i = 1; bif.jump_en_i = 1; bif.jump_addr_i = 32'h0000_0100;
    #1 got = snap();
    checks++;
    if (got !== {C_JMP, 3'b000} || bif.jump_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL jump_prio got=%b/%h exp=%b/00000100", got, bif.jump_addr_o, {C_JMP, 3'b000});
    end
    tick();
    idle();
    #1 got = snap();
    checks++;
    if (got !== 9'd0) begin errors++; $display("FAIL jump_after got=%b exp=0", got); end
    tick();
  endtask

  task automatic test_mdu_done();
    logic [8:0] got;
    logic [8:0] exp;
    bif.mdu_start_i = 1;
    for (int i = 0; i <= 5; i++) begin
      bif.jump_en_i   = (i == 2);
      bif.jump_addr_i = 32'h0000_0444;
      bif.mdu_done_i  = (i >= 4);
      bif.bus_stall_i = (i == 4);
      exp = (i == 0) ? {C_STL3, 3'b000} : (i < 5) ? {C_STL3, 3'b001} : {C_IDLE, 3'b001};
      #1 got = snap();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL mdu_done_c%0d got=%b exp=%b", i, got, exp); end
      tick();
      bif.mdu_start_i = 0;
    end
    idle();
    #1 got = snap();
    checks++;
    if (got !== 9'd0) begin errors++; $display("FAIL mdu_done_exit got=%b exp=0", got); end
    tick();
  endtask

  task automatic test_bus_jump();
    logic [8:0] got;
    logic [8:0] exp;
    for (int i = 0; i < 3; i++) begin
      bif.bus_stall_i = 1;
      bif.jump_en_i   = (i < 2);
      bif.jump_addr_i = (i == 0) ? 32'h0000_0200 : 32'h0000_0300;
      exp = {C_STL3, 1'b0, (i == 0) ? 2'd0 : 2'd2};
      #1 got = snap();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL busjmp_stall_c%0d got=%b exp=%b", i, got, exp); end
      tick();
    end
    idle();
    #1 got = snap();
    checks++;
    if (got !== {C_JMP, 3'b010} || bif.jump_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL busjmp_release got=%b/%h exp=%b/00000200", got, bif.jump_addr_o, {C_JMP, 3'b010});
    end
    tick();
    #1 got = snap();
    checks++;
    if (got !== 9'd0) begin errors++; $display("FAIL busjmp_after got=%b exp=0", got); end
    tick();
  endtask

  task automatic test_reset_mid_pend();
    logic [8:0] got;
    bif.bus_stall_i = 1; bif.jump_en_i = 1; bif.jump_addr_i = 32'h0000_0200;
    tick();
    bif.jump_en_i = 0;
    #1 got = snap();
    checks++;
    if (got !== {C_STL3, 3'b010}) begin errors++; $display("FAIL pend_enter got=%b exp=%b", got, {C_STL3, 3'b010}); end
    #1 rst = 0;
    #1 got = snap();
    checks++;
    if (got !== 9'd0 || bif.jump_addr_o !== '0) begin
      errors++;
      $display("FAIL pend_reset got=%b/%h exp=0/0", got, bif.jump_addr_o);
    end
    model_reset();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      bif.bus_stall_i = (i == 1);
      #1 got = snap();
      checks++;
      if (got !== ((i == 1) ? {C_STL3, 3'b000} : 9'd0)) begin
        errors++;
        $display("FAIL pend_discard_c%0d got=%b jaddr=%h exp_jump=0", i, got, bif.jump_addr_o);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_mdu_timeout();
    logic [8:0] got;
    logic [8:0] exp;
    bif.mdu_start_i = 1;
    for (int i = 0; i <= TMO; i++) begin
      exp = (i == 0) ? {C_STL3, 3'b000} : (i < TMO) ? {C_STL3, 3'b001} : {C_IDLE, 3'b001};
      #1 got = snap();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL mdu_tmo_c%0d got=%b exp=%b", i, got, exp); end
      tick();
      bif.mdu_start_i = 0;
    end
    for (int i = 0; i < 4; i++) begin
      bif.bus_stall_i = (i == 2);
      #1 got = snap();
      exp = {(i == 2) ? C_STL3 : C_IDLE, 3'b100};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL mdu_tmo_sticky_c%0d got=%b exp=%b", i, got, exp); end
      tick();
    end
    idle();
    rst = 0;
    #1 checks++;
    if (bif.mdu_timeout_o !== 1'b0) begin errors++; $display("FAIL mdu_tmo_clear got=%b exp=0", bif.mdu_timeout_o); end
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_random();
    logic [8:0]  got, exp;
    logic [31:0] exp_a;
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 99) != 0);
      if (!rst) model_reset();
      model_eval(exp, exp_a);
      #1 got = snap();
      checks++;
      if (got !== exp || bif.jump_addr_o !== exp_a) begin
        errors++;
        $display("FAIL random_c%0d got=%b/%h exp=%b/%h", i, got, bif.jump_addr_o, exp, exp_a);
      end
      tick();
    end
    rst = 1;
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_jump_priority();
    test_mdu_done();
    test_bus_jump();
    test_reset_mid_pend();
    test_mdu_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage RISC-V core. Drives stall (hold) and flush (insert `INST_NOP`) controls for the PC, IF/ID and ID/EX pipeline registers. Handles four cases:
- branch/jump redirects from EX;
- load-use hazards;
- multi-cycle MDU operations, with a timeout;
- external bus stalls, including a jump that arrives during a bus stall.

Parameters:
ADDR_W, 32, width of the jump target address
MDU_TIMEOUT, 64, max cycles in MDU_WAIT before forced abort
CNT_W, 7, MDU cycle counter width; 2^CNT_W > MDU_TIMEOUT is required

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
jump_en_i  input  1  EX resolved a taken branch/jump
jump_addr_i  input  ADDR_W  EX redirect target
ex_mem_read_i  input  1  instruction in EX is a load
ex_rd_addr_i  input  5  destination register of EX instruction
id_rs1_addr_i  input  5  rs1 of ID instruction
id_rs2_addr_i  input  5  rs2 of ID instruction
id_rs1_used_i  input  1  ID instruction reads rs1
id_rs2_used_i  input  1  ID instruction reads rs2
mdu_start_i  input  1  EX issues multi-cycle MDU op (1-cycle pulse)
mdu_done_i  input  1  MDU result valid
bus_stall_i  input  1  memory/bus not ready; freeze pipeline
stall_pc_o  output  1  hold PC
stall_if_id_o  output  1  hold IF/ID register
stall_id_ex_o  output  1  hold ID/EX register
flush_if_id_o  output  1  load NOP into IF/ID
flush_id_ex_o  output  1  load NOP into ID/EX
jump_en_o  output  1  redirect PC this cycle
jump_addr_o  output  ADDR_W  redirect target
mdu_timeout_o  output  1  sticky: an MDU op timed out
state_o  output  2  current FSM state, for debug

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, counter=0, pend_addr=0, mdu_timeout_o=0.
  - All stall/flush/jump_en_o outputs are forced 0; jump_addr_o=0.
- States: RUN=2'd0, MDU_WAIT=2'd1, JUMP_PEND=2'd2. Encoding 2'd3 is unreachable; if ever entered, return to RUN next cycle with outputs as RUN.
- Control outputs are combinational from state and inputs, with zero-cycle latency. Only state, counter, pend_addr and mdu_timeout_o are registered.
- Load-use hazard (LU) = ex_mem_read_i & (ex_rd_addr_i!=0) & ((id_rs1_used_i & id_rs1_addr_i==ex_rd_addr_i) | (id_rs2_used_i & id_rs2_addr_i==ex_rd_addr_i)).
- RUN, evaluated in strict priority order:
  1. bus_stall_i: assert stall_pc, stall_if_id, stall_id_ex; no flush; jump_en_o=0. If jump_en_i is also high, latch jump_addr_i into pend_addr and go to JUMP_PEND.
  2. jump_en_i: jump_en_o=1, jump_addr_o=jump_addr_i; flush_if_id=flush_id_ex=1; no stalls. This overrides LU and mdu_start_i.
  3. mdu_start_i: stall_pc, stall_if_id, stall_id_ex=1; counter<=0; go to MDU_WAIT.
  4. LU: stall_pc=stall_if_id=1, flush_id_ex=1 (one bubble). One cycle only; no state change.
  5. Otherwise: all outputs 0.
- MDU_WAIT:
  - Default: stall_pc, stall_if_id, stall_id_ex=1; counter increments by 1 each cycle.
  - bus_stall_i has no additional effect here; it only blocks exit: a done is accepted only when bus_stall_i=0.
  - mdu_done_i & !bus_stall_i: all stalls=0 in that same cycle; go to RUN.
  - counter==MDU_TIMEOUT-1 without an accepted done: stalls=0 that cycle, mdu_timeout_o<=1 (sticky until reset), go to RUN.
  - jump_en_i is ignored, since EX holds the MDU op.
- JUMP_PEND:
  - While bus_stall_i=1: all three stalls=1; jump_en_o=0.
  - When bus_stall_i=0: jump_en_o=1, jump_addr_o=pend_addr, flush_if_id=flush_id_ex=1, no stalls; go to RUN.
  - New jump_en_i is ignored while in JUMP_PEND.
- Stall and flush of the same register are never asserted together.
- Counter does not wrap: it saturates at MDU_TIMEOUT-1 by construction.
- Reset asserted mid-MDU_WAIT or mid-JUMP_PEND: the pending jump is discarded and the FSM returns to RUN immediately.

Test Plan:
1. Reset: hold rst=0 with all inputs toggling -> every output 0 and state_o=0. Release rst -> all outputs stay 0 with idle inputs.
2. Load-use: ex_mem_read_i=1, ex_rd_addr_i=5, id_rs2_addr_i=5, id_rs2_used_i=1 -> stall_pc=stall_if_id=1 and flush_id_ex=1 for exactly that cycle. Same stimulus with ex_rd_addr_i=0 -> no action.
3. Jump priority: jump_en_i=1 with jump_addr_i=0x0000_0100 while LU is also true -> jump_en_o=1, jump_addr_o=0x100, both flushes=1, no stalls.
4. MDU: pulse mdu_start_i, assert mdu_done_i 5 cycles later -> stalls high for 5 cycles, drop in the done cycle, state_o returns to 0. Repeat with no done -> stalls released after 64 cycles and mdu_timeout_o=1, held until reset.
5. Bus-stall + jump: bus_stall_i=1 for 3 cycles, jump_en_i=1 with 0x200 in the first of them -> stalls for 3 cycles with state_o=2. In the first cycle with bus_stall_i=0: jump_en_o=1, jump_addr_o=0x200, both flushes=1.
6. Reset mid-JUMP_PEND: drive rst=0 during the pending cycles -> state_o=0 immediately. After release, no jump_en_o is ever produced for the discarded 0x200.
